// File: rtl/ddr_rd_responder.sv
// DDR line-read responder: queues single-line read requests and returns one line
// from a preloadable on-chip store after a fixed, programmable latency.
module ddr_rd_responder #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 512,
   parameter int DEPTH      = 128,
   parameter int LATENCY    = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ddr_rd,
   input  logic [ADDR_WIDTH-1:0]    readAdd,
   output logic                     ddr_rd_valid,
   output logic [DATA_WIDTH-1:0]    ddr_rd_data,
   output logic                     ddr_rd_done,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_line,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   output logic                     busy,
   output logic                     ovf_err,
   output logic                     range_err
);
   // state | meaning
   // IDLE  | no request in service, waiting for the FIFO to go non-empty
   // WAIT  | request popped, latency counter running down to zero
   // RESP  | one-cycle response pulse; may pop the next request on exit
   localparam int LW   = $clog2(DEPTH);
   localparam int IW   = ADDR_WIDTH - 9;
   localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNTW = $clog2(FIFO_DEPTH + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   logic [IW-1:0]         req_idx;
   logic                  req_oor;
   logic [LW:0]           req_ent;
   logic [LW:0]           fifo_q [FIFO_DEPTH];
   logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [CNTW-1:0]       cnt_q;
   logic                  fifo_empty, fifo_full, pop, push;
   state_t                state_q;
   logic [3:0]            lat_q;
   logic [LW:0]           cur_q;
   logic [DATA_WIDTH-1:0] store_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_line_d;
   logic                  unused_low;

   assign unused_low = ^readAdd[8:0];
   assign req_idx    = readAdd[ADDR_WIDTH-1:9];
   assign req_oor    = (req_idx >= IW'(DEPTH));
   assign req_ent    = {req_oor, req_idx[LW-1:0]};
   assign fifo_empty = (cnt_q == '0);
   assign fifo_full  = (cnt_q == CNTW'(FIFO_DEPTH));
   assign pop        = !fifo_empty && (state_q != WAIT);
   // A full FIFO that pops on this edge still has room for the push.
   assign push       = ddr_rd && (!fifo_full || pop);
   assign busy       = !fifo_empty || (state_q != IDLE);

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push) fifo_q[wr_ptr_q] <= req_ent;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         cnt_q     <= '0;
         ovf_err   <= 1'b0;
         range_err <= 1'b0;
      end else begin
         if (push) wr_ptr_q <= next_ptr(wr_ptr_q);
         if (pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
         case ({push, pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (ddr_rd && !push) ovf_err   <= 1'b1;
         if (ddr_rd && req_oor) range_err <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) store_q[wr_line] <= wr_data;
   end

   // Write-first: a preload to the line being read on this edge wins.
   always_comb begin
      rd_line_d = store_q[cur_q[LW-1:0]];
      if (wr_en && (wr_line == cur_q[LW-1:0])) rd_line_d = wr_data;
      if (cur_q[LW]) rd_line_d = '0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         lat_q        <= '0;
         cur_q        <= '0;
         ddr_rd_valid <= 1'b0;
         ddr_rd_done  <= 1'b0;
         ddr_rd_data  <= '0;
      end else begin
         ddr_rd_valid <= 1'b0;
         ddr_rd_done  <= 1'b0;
         case (state_q)
            IDLE, RESP: begin
               if (pop) begin
                  cur_q   <= fifo_q[rd_ptr_q];
                  lat_q   <= 4'(LATENCY - 2);
                  state_q <= WAIT;
               end else begin
                  state_q <= IDLE;
               end
            end
            WAIT: begin
               if (lat_q == '0) begin
                  ddr_rd_data  <= rd_line_d;
                  ddr_rd_valid <= 1'b1;
                  ddr_rd_done  <= 1'b1;
                  state_q      <= RESP;
               end else begin
                  lat_q <= lat_q - 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ddr_rd_responder.sv
// Bench for ddr_rd_responder: two instances (latency 4 and 8) checked every cycle
// against a request-scheduling reference model built from the timing rules.
module tb_ddr_rd_responder;
   localparam int AW = 32;
   localparam int DW = 512;
   localparam int DEPTH = 128;
   localparam int FD = 4;
   localparam int LAT [2] = '{4, 8};

   typedef struct {
      int d;
      int push;
      int pop;
      int resp;
      int line;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          rd [2];
   logic [AW-1:0] addr [2];
   logic          wr_en = 1'b0;
   logic [6:0]    wr_line = '0;
   logic [DW-1:0] wr_data = '0;
   logic          vld [2], dne [2], bsy [2], ovf [2], rng [2];
   logic [DW-1:0] dat [2];

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;
   int resp_cnt [2];
   int resp_cyc0 [$];
   exp_t expq [$];
   int last_resp [2];
   logic ovf_m [2], rng_m [2];
   logic [DW-1:0] dat_m [2];
   logic [DW-1:0] mem_m [DEPTH];

   always #5 clk = ~clk;

   ddr_rd_responder #(.LATENCY(4)) u_dut0 (
      .clk(clk), .rst(rst), .ddr_rd(rd[0]), .readAdd(addr[0]),
      .ddr_rd_valid(vld[0]), .ddr_rd_data(dat[0]), .ddr_rd_done(dne[0]),
      .wr_en(wr_en), .wr_line(wr_line), .wr_data(wr_data),
      .busy(bsy[0]), .ovf_err(ovf[0]), .range_err(rng[0]));

   ddr_rd_responder #(.LATENCY(8)) u_dut1 (
      .clk(clk), .rst(rst), .ddr_rd(rd[1]), .readAdd(addr[1]),
      .ddr_rd_valid(vld[1]), .ddr_rd_data(dat[1]), .ddr_rd_done(dne[1]),
      .wr_en(wr_en), .wr_line(wr_line), .wr_data(wr_data),
      .busy(bsy[1]), .ovf_err(ovf[1]), .range_err(rng[1]));

   task automatic chk(input string tag, input int d, input logic [DW-1:0] got,
                      input logic [DW-1:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s dut%0d: observed %h expected %h", tag, d, got, exp);
      end
   endtask

   // A request is dropped when FD earlier requests are still waiting past this edge;
   // otherwise it is popped once the responder is free and answers LATENCY-1 later.
   task automatic model_push(input int d, input logic [AW-1:0] a);
      int line, occ, p;
      exp_t e;
      line = int'(a >> 9);
      occ = 0;
      if (line >= DEPTH) rng_m[d] = 1'b1;
      foreach (expq[i]) if (expq[i].d == d && expq[i].pop > cyc) occ++;
      if (occ >= FD) begin
         ovf_m[d] = 1'b1;
      end else begin
         p = (cyc + 1 > last_resp[d] + 1) ? cyc + 1 : last_resp[d] + 1;
         e.d = d; e.push = cyc; e.pop = p; e.resp = p + LAT[d] - 1; e.line = line;
         last_resp[d] = e.resp;
         expq.push_back(e);
      end
   endtask

   int   idx;
   logic exp_v;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (wr_en) mem_m[wr_line] = wr_data;
      if (!rst) begin
         expq.delete();
         for (int d = 0; d < 2; d++) begin
            last_resp[d] = -1000; ovf_m[d] = 1'b0; rng_m[d] = 1'b0; dat_m[d] = '0;
            chk("rst_valid", d, vld[d], 0);
            chk("rst_done", d, dne[d], 0);
            chk("rst_data", d, dat[d], 0);
            chk("rst_busy", d, bsy[d], 0);
            chk("rst_ovf", d, ovf[d], 0);
            chk("rst_range", d, rng[d], 0);
         end
      end else begin
         for (int d = 0; d < 2; d++) if (rd[d]) model_push(d, addr[d]);
         for (int d = 0; d < 2; d++) begin
            idx = -1;
            for (int i = expq.size() - 1; i >= 0; i--) if (expq[i].d == d) idx = i;
            exp_v = (idx >= 0) && (expq[idx].resp == cyc);
            chk("busy", d, bsy[d], idx >= 0);
            if (exp_v) begin
               dat_m[d] = (expq[idx].line >= DEPTH) ? '0 : mem_m[expq[idx].line];
               expq.delete(idx);
            end
            chk("valid", d, vld[d], exp_v);
            chk("done", d, dne[d], exp_v);
            chk("data", d, dat[d], dat_m[d]);
            chk("ovf_err", d, ovf[d], ovf_m[d]);
            chk("range_err", d, rng[d], rng_m[d]);
            if (vld[d]) begin
               resp_cnt[d]++;
               if (d == 0) resp_cyc0.push_back(cyc);
            end
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input int line, input logic [DW-1:0] data);
      @(negedge clk);
      wr_en = 1'b1; wr_line = 7'(line); wr_data = data;
      @(negedge clk);
      wr_en = 1'b0;
   endtask

   task automatic req(input int d, input logic [AW-1:0] a);
      @(negedge clk);
      rd[d] = 1'b1; addr[d] = a;
      @(negedge clk);
      rd[d] = 1'b0;
   endtask

   function automatic logic [DW-1:0] rand_line();
      logic [DW-1:0] v;
      for (int j = 0; j < DW / 32; j++) v[j*32 +: 32] = $urandom;
      return v;
   endfunction

   initial begin
      int lines [4];
      lines = '{0, 4, 7, 9};
      rd[0] = 1'b0; rd[1] = 1'b0; addr[0] = '0; addr[1] = '0;
      resp_cnt[0] = 0; resp_cnt[1] = 0;

      idle(5);
      rst = 1'b1;
      idle(5);

      for (int l = 0; l < DEPTH; l++) wr(l, (l == 9) ? 512'h1234abcd : rand_line());
      idle(2);

      req(0, 32'd4608);
      idle(8);
      req(0, 32'd4608 + 32'h1FF);
      idle(8);

      resp_cyc0.delete();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         rd[0] = 1'b1; addr[0] = 32'(lines[i] * 512);
      end
      @(negedge clk);
      rd[0] = 1'b0;
      idle(20);
      chk("b2b_count", 0, resp_cyc0.size(), 4);
      if (resp_cyc0.size() == 4)
         for (int i = 1; i < 4; i++) chk("b2b_spacing", 0, resp_cyc0[i] - resp_cyc0[i-1], 4);
      chk("b2b_ovf", 0, ovf[0], 0);

      resp_cnt[1] = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         rd[1] = 1'b1; addr[1] = 32'($urandom_range(0, DEPTH - 1) * 512);
      end
      @(negedge clk);
      rd[1] = 1'b0;
      idle(60);
      chk("ovf_resp_count", 1, resp_cnt[1], 5);
      chk("ovf_sticky", 1, ovf[1], 1);

      req(0, 32'(200 * 512));
      idle(8);
      chk("range_sticky", 0, rng[0], 1);
      chk("range_data", 0, dat[0], 0);

      @(negedge clk);
      rd[0] = 1'b1; addr[0] = 32'd4608;
      @(negedge clk);
      rd[0] = 1'b0;
      idle(3);
      wr_en = 1'b1; wr_line = 7'd9; wr_data = '1;
      @(negedge clk);
      wr_en = 1'b0;
      chk("collision_valid", 0, vld[0], 1);
      chk("collision_data", 0, dat[0], {DW{1'b1}});
      idle(4);

      for (int i = 0; i < 40; i++) begin
         idle($urandom_range(0, 5));
         @(negedge clk);
         rd[0] = 1'b1;
         addr[0] = 32'($urandom_range(0, DEPTH - 1) * 512 + $urandom_range(0, 511));
         if ($urandom_range(0, 9) < 3) begin
            wr_en = 1'b1; wr_line = 7'($urandom_range(0, DEPTH - 1)); wr_data = rand_line();
         end
         @(negedge clk);
         rd[0] = 1'b0; wr_en = 1'b0;
      end
      idle(40);

      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         rd[0] = 1'b1; addr[0] = 32'((i + 1) * 512);
      end
      @(negedge clk);
      rd[0] = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      rst = 1'b1;
      resp_cnt[0] = 0;
      idle(20);
      chk("midrst_no_resp", 0, resp_cnt[0], 0);
      chk("midrst_busy", 0, bsy[0], 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
